// File: rtl/patch_fetch_dram.sv
// -----------------------------------------------------------------------------
// patch_fetch_dram
//   Image frame memory with a sequential square-patch read engine. A pixel
//   writer fills the frame one pixel at a time. A patch request supplies a
//   centre (x,y). The engine then gathers the (2R+1)x(2R+1) neighbourhood one
//   row per cycle into a single flat output word. Pixels that fall outside the
//   frame read as PAD_VAL, so addresses never wrap across rows or frame edges.
//
// Ports
//   clk        in   1                    clock, all state on rising edge
//   rst_n      in   1                    asynchronous active-low reset
//   wen        in   1                    pixel write strobe
//   waddr      in   A_WIDTH              write address = y*IMG_W + x
//   wdata      in   D_WIDTH              write pixel
//   wready     out  1                    write accepted this cycle (IDLE only)
//   req_valid  in   1                    patch request valid
//   req_ready  out  1                    engine idle, accepts a request
//   req_x      in   X_W                  centre column
//   req_y      in   Y_W                  centre row
//   rvalid     out  1                    patch complete, rdata valid
//   rready     in   1                    consumer accepts patch
//   rdata      out  PATCH*PATCH*D_WIDTH  patch, top row in MSBs, leftmost
//                                        column in the MSBs of each row
//   busy       out  1                    engine not idle
// -----------------------------------------------------------------------------
module patch_fetch_dram #(
  parameter int                 D_WIDTH = 8,
  parameter int                 IMG_W   = 1280,
  parameter int                 IMG_H   = 720,
  parameter int                 R       = 15,
  parameter int                 X_W     = 11,
  parameter int                 Y_W     = 10,
  parameter int                 A_WIDTH = 20,
  parameter logic [D_WIDTH-1:0] PAD_VAL = '0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        wen,
  input  logic [A_WIDTH-1:0]                          waddr,
  input  logic [D_WIDTH-1:0]                          wdata,
  output logic                                        wready,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [X_W-1:0]                              req_x,
  input  logic [Y_W-1:0]                              req_y,
  output logic                                        rvalid,
  input  logic                                        rready,
  output logic [(2*R+1)*(2*R+1)*D_WIDTH-1:0]          rdata,
  output logic                                        busy
);

  localparam int PATCH = 2 * R + 1;
  localparam int ROW_W = PATCH * D_WIDTH;
  localparam int PIX   = IMG_W * IMG_H;
  localparam int MA_W  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int CNT_W = $clog2(PATCH + 1);

  localparam logic [A_WIDTH-1:0] PIX_A    = A_WIDTH'(PIX);
  localparam logic [CNT_W-1:0]   LAST_ROW = CNT_W'(PATCH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [X_W-1:0]             r_x;
  logic [Y_W-1:0]             r_y;
  logic [CNT_W-1:0]           r_cnt;
  logic [PATCH*ROW_W-1:0]     r_rdata;
  logic [D_WIDTH-1:0]         r_mem [PIX];

  logic signed [31:0]         w_rowY;
  logic signed [31:0]         w_colX0;
  logic [ROW_W-1:0]           w_row;
  logic                       w_wr;

  // Reads one pixel with signed coordinates; anything outside the frame
  // returns the pad value instead of wrapping into a neighbouring row.
  function automatic logic [D_WIDTH-1:0] f_pixel(input logic signed [31:0] px,
                                                 input logic signed [31:0] py);
    if (px < 0 || px >= IMG_W || py < 0 || py >= IMG_H)
      return PAD_VAL;
    return r_mem[MA_W'(py * IMG_W + px)];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid)          w_next = FETCH;
      FETCH:   if (r_cnt == LAST_ROW)  w_next = DONE;
      DONE:    if (rready)             w_next = IDLE;
      default:                         w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wready    = (r_state == IDLE);
    req_ready = (r_state == IDLE);
    rvalid    = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  // Current patch row: image row is centre row minus R plus the row counter,
  // leftmost column lands in the most significant pixel slot.
  always_comb begin
    w_rowY  = $signed(32'(r_y)) - R + $signed(32'(r_cnt));
    w_colX0 = $signed(32'(r_x)) - R;
    w_row   = '0;
    for (int c = 0; c < PATCH; c++)
      w_row[(PATCH-1-c)*D_WIDTH +: D_WIDTH] = f_pixel(w_colX0 + c, w_rowY);
  end

  // Request capture, row counter and patch assembly; rdata keeps the last
  // patch after DONE until the next fetch overwrites it row by row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_x   <= req_x;
            r_y   <= req_y;
            r_cnt <= '0;
          end
        end
        FETCH: begin
          for (int i = 0; i < PATCH; i++)
            if (r_cnt == CNT_W'(i))
              r_rdata[(PATCH-1-i)*ROW_W +: ROW_W] <= w_row;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Writes only land while idle, so a write accepted together with a request
  // is already in memory when the first row is read.
  assign w_wr = wen && (r_state == IDLE) && (waddr < PIX_A);

  // Frame memory, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[waddr[MA_W-1:0]] <= wdata;
  end

  assign rdata = r_rdata;

endmodule
